// File: rtl/uart_boot_loader.sv
// UART program loader: receives a length-prefixed, XOR-checksummed image
// and writes it word-by-word into main memory, holding the core in reset.
module uart_boot_loader #(
    parameter int CLK_DIV   = 868,
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              boot_done,
    output logic              boot_err,
    output logic [15:0]       words_loaded
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [15:0]   MAXW = 16'(MAX_WORDS);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] LEN0 = 3'd0;
    localparam logic [2:0] LEN1 = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] CSUM = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    logic          rx_s1, rx_s2, rx_prev;
    logic [1:0]    rx_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shreg;
    logic          byte_valid, frame_err;

    logic [2:0]    state;
    logic [15:0]   len;
    logic [1:0]    bcnt;
    logic [23:0]   wbuf;
    logic [7:0]    csum;
    logic [15:0]   n_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt      <= '0;
                        bitn     <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shreg <= {rx_s2, shreg[7:1]};
                        bitn  <= bitn + 1'b1;
                        if (bitn == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt        <= '0;
                        rx_state   <= RX_IDLE;
                        byte_valid <= rx_s2;
                        frame_err  <= !rx_s2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign n_full = {shreg, len[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LEN0;
            len          <= '0;
            bcnt         <= '0;
            wbuf         <= '0;
            csum         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            // Once the image is accepted the line is dead to us.
            if (frame_err && state != DONE && state != ERR) begin
                state <= ERR;
            end else if (byte_valid) begin
                case (state)
                    LEN0: begin
                        len[7:0] <= shreg;
                        csum     <= shreg;
                        state    <= LEN1;
                    end
                    LEN1: begin
                        len[15:8] <= shreg;
                        csum      <= csum ^ shreg;
                        bcnt      <= '0;
                        if (n_full > MAXW)       state <= ERR;
                        else if (n_full == 16'd0) state <= CSUM;
                        else                      state <= DATA;
                    end
                    DATA: begin
                        csum <= csum ^ shreg;
                        bcnt <= bcnt + 1'b1;
                        case (bcnt)
                            2'd0: wbuf[7:0]   <= shreg;
                            2'd1: wbuf[15:8]  <= shreg;
                            2'd2: wbuf[23:16] <= shreg;
                            default: begin
                                mem_we       <= 1'b1;
                                mem_addr     <= {words_loaded[ADDR_W-3:0], 2'b00};
                                mem_wdata    <= {shreg, wbuf};
                                words_loaded <= words_loaded + 16'd1;
                                if (words_loaded + 16'd1 == len) state <= CSUM;
                            end
                        endcase
                    end
                    CSUM: state <= (shreg == csum) ? DONE : ERR;
                    default: ;
                endcase
            end
        end
    end

    assign core_rst  = (state != DONE);
    assign boot_done = (state == DONE);
    assign boot_err  = (state == ERR);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected memory writes are queued
// by the stimulus and popped by a monitor whenever mem_we is seen.
module tb_uart_boot_loader;

    localparam int CLK_DIV = 16;
    localparam int ADDR_W  = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx  = 1'b1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst, boot_done, boot_err;
    logic [15:0]       words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    logic [43:0] exp_q[$];
    logic [7:0]  stream[$];

    uart_boot_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexp: got addr %h data %h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_bad++;
                    $display("FAIL wr: got addr %h data %h expected addr %h data %h",
                             mem_addr, mem_wdata, e[43:32], e[31:0]);
                end
            end
        end
    end

    task automatic expect_wr(input logic [11:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_stream();
        foreach (stream[i]) send_byte(stream[i], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic load_s1();
        stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("q_empty_pre", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_done", boot_done, 0);
        check("rst_err", boot_err, 0);
        check("rst_words", words_loaded, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single word; checksum 01^00^13^05^A0^00 = B7
        expect_wr(12'h000, 32'h00A00513);
        stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        send_stream();
        check("s1_core_rst_pre", core_rst, 1);
        check("s1_done_pre", boot_done, 0);
        send_byte(8'hB7, 1'b1);
        repeat (4) @(negedge clk);
        check("s1_core_rst", core_rst, 0);
        check("s1_done", boot_done, 1);
        check("s1_err", boot_err, 0);
        check("s1_words", words_loaded, 1);
        check("s1_q", exp_q.size(), 0);
        // Traffic after DONE, including a bad stop bit, is ignored
        load_s1();
        send_stream();
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check("s1_post_done", boot_done, 1);
        check("s1_post_err", boot_err, 0);
        check("s1_post_words", words_loaded, 1);

        // Three words; checksum 03^00 = 03 (each repeated word cancels)
        do_reset();
        expect_wr(12'h000, 32'h11111111);
        expect_wr(12'h004, 32'h22222222);
        expect_wr(12'h008, 32'h33333333);
        stream = '{8'h03, 8'h00,
                   8'h11, 8'h11, 8'h11, 8'h11,
                   8'h22, 8'h22, 8'h22, 8'h22,
                   8'h33, 8'h33, 8'h33, 8'h33, 8'h03};
        send_stream();
        check("s2_words", words_loaded, 3);
        check("s2_done", boot_done, 1);
        check("s2_core_rst", core_rst, 0);
        check("s2_q", exp_q.size(), 0);

        // Bad checksum
        do_reset();
        expect_wr(12'h000, 32'h00A00513);
        stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h00};
        send_stream();
        check("s3_err", boot_err, 1);
        check("s3_core_rst", core_rst, 1);
        check("s3_done", boot_done, 0);
        check("s3_q", exp_q.size(), 0);
        load_s1();
        send_stream();
        check("s3_err_sticky", boot_err, 1);
        check("s3_core_rst2", core_rst, 1);
        check("s3_words", words_loaded, 1);

        // Oversize: N = 0x0401 = 1025
        do_reset();
        send_byte(8'h01, 1'b1);
        check("s4_err_pre", boot_err, 0);
        send_byte(8'h04, 1'b1);
        check("s4_err", boot_err, 1);
        stream = '{8'h13, 8'h05, 8'hA0, 8'h00};
        send_stream();
        check("s4_words", words_loaded, 0);
        check("s4_core_rst", core_rst, 1);

        // Framing error in DATA
        do_reset();
        stream = '{8'h01, 8'h00};
        send_stream();
        check("s5_err_pre", boot_err, 0);
        send_byte(8'h13, 1'b0);
        repeat (4) @(negedge clk);
        check("s5_err", boot_err, 1);
        check("s5_core_rst", core_rst, 1);

        // 3-cycle glitch is rejected; a full image then loads cleanly
        do_reset();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("s6_err", boot_err, 0);
        expect_wr(12'h000, 32'h00A00513);
        load_s1();
        send_stream();
        check("s6_done", boot_done, 1);
        check("s6_q", exp_q.size(), 0);

        // Mid-transfer reset after one complete word and half of the next
        do_reset();
        expect_wr(12'h000, 32'hDEADBEEF);
        stream = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02};
        send_stream();
        check("s7_words_pre", words_loaded, 1);
        check("s7_q_pre", exp_q.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("s7_rst_addr", mem_addr, 0);
        check("s7_rst_wdata", mem_wdata, 0);
        check("s7_rst_words", words_loaded, 0);
        check("s7_rst_core_rst", core_rst, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        expect_wr(12'h000, 32'h00A00513);
        load_s1();
        send_stream();
        check("s7_done", boot_done, 1);
        check("s7_words", words_loaded, 1);
        check("s7_q", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
